mux_scan_sequencer: RTL and testbench

Upstream control stage for the 8-to-1 multiplexer. On a START request it captures an 8-bit word, drives it onto the mux data inputs I7..I0, and steps the select lines S2..S0 through all eight positions. The result is a serial bitstream on the mux output O, with per-bit strobes and a completion pulse. It also reads O back from the mux and flags any bit that does not match the captured word.

---
 rtl/mux_scan_sequencer_if.sv | 25 ++
 rtl/mux_scan_sequencer.sv | 125 ++++++++++++
 tb/tb_mux_scan_sequencer.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mux_scan_sequencer_if.sv
// Signal bundle between a requester and the mux scan sequencer, including the mux-side
// data/select lines and the readback from the mux output.
interface mux_scan_sequencer_if;
  logic       START;
  logic       ABORT;
  logic       DIR;
  logic [7:0] D;
  logic       O;
  logic       I7, I6, I5, I4, I3, I2, I1, I0;
  logic       S2, S1, S0;
  logic       BUSY;
  logic       BIT_VALID;
  logic       DONE;
  logic       ERR;

  modport master (
    output START, ABORT, DIR, D, O,
    input  I7, I6, I5, I4, I3, I2, I1, I0, S2, S1, S0, BUSY, BIT_VALID, DONE, ERR
  );

  modport slave (
    input  START, ABORT, DIR, D, O,
    output I7, I6, I5, I4, I3, I2, I1, I0, S2, S1, S0, BUSY, BIT_VALID, DONE, ERR
  );
endinterface

// File: rtl/mux_scan_sequencer.sv
// Serializes a captured byte through an 8-to-1 mux by stepping its select lines, and checks
// the mux output readback against the captured word.
module mux_scan_sequencer #(
  parameter int unsigned BIT_CYCLES = 1
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  mux_scan_sequencer_if.slave  bus
);

  localparam int unsigned     CntW   = $clog2(BIT_CYCLES) + 1;
  localparam logic [CntW-1:0] CntMax = CntW'(BIT_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      data_q, data_d;
  logic [2:0]      sel_q, sel_d;
  logic            dir_q, dir_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;

  logic start_ok;
  logic hold_end;
  logic last_idx;
  logic strobe;

  always_comb begin
    start_ok = bus.START & ~bus.ABORT;
    hold_end = (cnt_q == CntMax);
    last_idx = dir_q ? (sel_q == 3'd0) : (sel_q == 3'd7);
    strobe   = (state_q == StShift) && (cnt_q == '0);
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start_ok) begin
          state_d = StShift;
          data_d  = bus.D;
          dir_d   = bus.DIR;
          sel_d   = bus.DIR ? 3'd7 : 3'd0;
          cnt_d   = '0;
          err_d   = 1'b0;
        end else begin
          state_d = StIdle;
          sel_d   = 3'd0;
        end
      end
      StShift: begin
        if (bus.ABORT) begin
          // Captured word and ERR survive an abort; only the scan position is dropped.
          state_d = StIdle;
          sel_d   = 3'd0;
          cnt_d   = '0;
        end else begin
          if (strobe && (bus.O != data_q[sel_q])) begin
            err_d = 1'b1;
          end
          if (hold_end) begin
            cnt_d = '0;
            if (last_idx) begin
              state_d = StDone;
            end else begin
              sel_d = dir_q ? (sel_q - 3'd1) : (sel_q + 3'd1);
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        sel_d   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= StIdle;
      data_q  <= 8'd0;
      sel_q   <= 3'd0;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign bus.I0 = data_q[0];
  assign bus.I1 = data_q[1];
  assign bus.I2 = data_q[2];
  assign bus.I3 = data_q[3];
  assign bus.I4 = data_q[4];
  assign bus.I5 = data_q[5];
  assign bus.I6 = data_q[6];
  assign bus.I7 = data_q[7];

  assign bus.S2 = sel_q[2];
  assign bus.S1 = sel_q[1];
  assign bus.S0 = sel_q[0];

  assign bus.BUSY      = (state_q == StShift);
  assign bus.BIT_VALID = strobe;
  assign bus.DONE      = (state_q == StDone);
  assign bus.ERR       = err_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: two instances (BIT_CYCLES 1 and 3) share one stimulus stream
// and are compared every cycle against a scan-position model, plus directed vectors.
module tb_mux_scan_sequencer;

  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  logic       start, abort, dir, o_rand;
  logic [7:0] d;
  logic [1:0] omode;  // 0: mux loopback, 1: O stuck at 0, 2: random O

  mux_scan_sequencer_if bus1 ();
  mux_scan_sequencer_if bus3 ();

  mux_scan_sequencer #(.BIT_CYCLES(1)) u_dut1 (.CLK(CLK), .RST_N(RST_N), .bus(bus1));
  mux_scan_sequencer #(.BIT_CYCLES(3)) u_dut3 (.CLK(CLK), .RST_N(RST_N), .bus(bus3));

  assign bus1.START = start;
  assign bus1.ABORT = abort;
  assign bus1.DIR   = dir;
  assign bus1.D     = d;
  assign bus3.START = start;
  assign bus3.ABORT = abort;
  assign bus3.DIR   = dir;
  assign bus3.D     = d;

  wire [7:0] i1 = {bus1.I7, bus1.I6, bus1.I5, bus1.I4, bus1.I3, bus1.I2, bus1.I1, bus1.I0};
  wire [7:0] i3 = {bus3.I7, bus3.I6, bus3.I5, bus3.I4, bus3.I3, bus3.I2, bus3.I1, bus3.I0};
  wire [2:0] s1 = {bus1.S2, bus1.S1, bus1.S0};
  wire [2:0] s3 = {bus3.S2, bus3.S1, bus3.S0};
  wire       mux1 = i1[s1];
  wire       mux3 = i3[s3];

  assign bus1.O = (omode == 2'd0) ? mux1 : (omode == 2'd1) ? 1'b0 : o_rand;
  assign bus3.O = (omode == 2'd0) ? mux3 : (omode == 2'd1) ? 1'b0 : o_rand;

  wire [14:0] act1 = {i1, s1, bus1.BUSY, bus1.BIT_VALID, bus1.DONE, bus1.ERR};
  wire [14:0] act3 = {i3, s3, bus3.BUSY, bus3.BIT_VALID, bus3.DONE, bus3.ERR};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a scan is "elapsed cycles t of 8*bc"; index and strobe derive from t arithmetically.
  bit         m_act  [2];
  int         m_t    [2];
  bit         m_done [2];
  logic [7:0] m_word [2];
  bit         m_dir  [2];
  bit         m_err  [2];

  function automatic int bcof(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic logic [2:0] m_sel(input int k);
    int n;
    if (m_act[k]) begin
      n = m_t[k] / bcof(k);
      return 3'(m_dir[k] ? 7 - n : n);
    end
    if (m_done[k]) return m_dir[k] ? 3'd0 : 3'd7;
    return 3'd0;
  endfunction

  function automatic logic [14:0] m_exp(input int k);
    logic strobe;
    strobe = m_act[k] && ((m_t[k] % bcof(k)) == 0);
    return {m_word[k], m_sel(k), m_act[k], strobe, m_done[k], m_err[k]};
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      m_act[k] = 0; m_t[k] = 0; m_done[k] = 0; m_word[k] = 8'd0; m_dir[k] = 0; m_err[k] = 0;
    end
  endtask

  task automatic m_step(input int k);
    int   b;
    logic o;
    b = bcof(k);
    o = (omode == 2'd0) ? m_word[k][m_sel(k)] : (omode == 2'd1) ? 1'b0 : o_rand;
    if (m_act[k]) begin
      if (abort) begin
        m_act[k] = 0;
      end else begin
        if (((m_t[k] % b) == 0) && (o != m_word[k][m_sel(k)])) m_err[k] = 1;
        m_t[k]++;
        if (m_t[k] == 8 * b) begin
          m_act[k]  = 0;
          m_done[k] = 1;
        end
      end
    end else begin
      m_done[k] = 0;
      if (start && !abort) begin
        m_act[k] = 1; m_t[k] = 0; m_word[k] = d; m_dir[k] = dir; m_err[k] = 0;
      end
    end
  endtask

  // Inputs change at negedge; one rising edge; model and DUTs compared 1 time unit later.
  task automatic cycle();
    @(posedge CLK);
    m_step(0);
    m_step(1);
    #1;
    check("model_bc1", act1, m_exp(0));
    check("model_bc3", act3, m_exp(1));
    @(negedge CLK);
  endtask

  typedef struct packed {
    logic       st, ab, dr;
    logic [7:0] d;
    logic [1:0] om;
    logic [2:0] sel;
    logic       b, v, dn, e, o;
  } vec_t;

  function automatic vec_t r(input logic st, ab, dr, input logic [7:0] dd, input logic [1:0] om,
                             input logic [2:0] sel, input logic b, v, dn, e, o);
    vec_t x;
    x = '{st: st, ab: ab, dr: dr, d: dd, om: om, sel: sel, b: b, v: v, dn: dn, e: e, o: o};
    return x;
  endfunction

  vec_t tbl[$];

  int busy_n, bv_n, bv_first, bv_last, done_n, done_c;

  initial begin
    // Expected BIT_CYCLES=1 behaviour after each edge: sel, BUSY, BIT_VALID, DONE, ERR, mux O.
    tbl.push_back(r(1, 0, 0, 8'hA5, 0, 0, 1, 1, 0, 0, 1));
    tbl.push_back(r(0, 0, 0, 8'h00, 0, 1, 1, 1, 0, 0, 0));
    tbl.push_back(r(0, 0, 0, 8'h00, 0, 2, 1, 1, 0, 0, 1));
    tbl.push_back(r(0, 0, 0, 8'h00, 0, 3, 1, 1, 0, 0, 0));
    tbl.push_back(r(0, 0, 0, 8'h00, 0, 4, 1, 1, 0, 0, 0));
    tbl.push_back(r(0, 0, 0, 8'h00, 0, 5, 1, 1, 0, 0, 1));
    tbl.push_back(r(0, 0, 0, 8'h00, 0, 6, 1, 1, 0, 0, 0));
    tbl.push_back(r(0, 0, 0, 8'h00, 0, 7, 1, 1, 0, 0, 1));
    tbl.push_back(r(0, 0, 0, 8'h00, 0, 7, 0, 0, 1, 0, 1));  // DONE holds last index
    tbl.push_back(r(0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(r(1, 1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 1));  // ABORT beats START in IDLE
    tbl.push_back(r(1, 0, 0, 8'h10, 1, 0, 1, 1, 0, 0, 0));  // O stuck at 0
    tbl.push_back(r(0, 0, 0, 8'h00, 1, 1, 1, 1, 0, 0, 0));
    tbl.push_back(r(0, 0, 0, 8'h00, 1, 2, 1, 1, 0, 0, 0));
    tbl.push_back(r(0, 0, 0, 8'h00, 1, 3, 1, 1, 0, 0, 0));
    tbl.push_back(r(0, 0, 0, 8'h00, 1, 4, 1, 1, 0, 0, 1));
    tbl.push_back(r(0, 0, 0, 8'h00, 1, 5, 1, 1, 0, 1, 0));
    tbl.push_back(r(0, 0, 0, 8'h00, 1, 6, 1, 1, 0, 1, 0));
    tbl.push_back(r(0, 0, 0, 8'h00, 1, 7, 1, 1, 0, 1, 0));
    tbl.push_back(r(0, 0, 0, 8'h00, 1, 7, 0, 0, 1, 1, 0));
    tbl.push_back(r(1, 0, 1, 8'h3C, 0, 7, 1, 1, 0, 0, 0));  // START in DONE, clears ERR
    tbl.push_back(r(1, 0, 0, 8'hFF, 0, 6, 1, 1, 0, 0, 0));  // START mid-scan ignored
    tbl.push_back(r(0, 0, 0, 8'h00, 0, 5, 1, 1, 0, 0, 1));
    tbl.push_back(r(0, 1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0));  // ABORT: I held at 3C
    tbl.push_back(r(0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(r(1, 0, 0, 8'hFF, 0, 0, 1, 1, 0, 0, 1));
    tbl.push_back(r(0, 0, 0, 8'h00, 0, 1, 1, 1, 0, 0, 1));
    tbl.push_back(r(0, 0, 0, 8'h00, 0, 2, 1, 1, 0, 0, 1));
    tbl.push_back(r(0, 1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 1));  // ABORT in third hold
    tbl.push_back(r(0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 1));  // no DONE pulse

    start = 0; abort = 0; dir = 0; d = 8'd0; omode = 2'd0; o_rand = 0;
    RST_N = 1'b1;
    m_reset();
    #1 RST_N = 1'b0;
    #1;
    check("reset_bc1", act1, 15'd0);
    check("reset_bc3", act3, 15'd0);
    @(negedge CLK);
    RST_N = 1'b1;

    foreach (tbl[i]) begin
      start = tbl[i].st; abort = tbl[i].ab; dir = tbl[i].dr; d = tbl[i].d; omode = tbl[i].om;
      cycle();
      check($sformatf("vec%0d", i), {s1, bus1.BUSY, bus1.BIT_VALID, bus1.DONE, bus1.ERR, mux1},
            {tbl[i].sel, tbl[i].b, tbl[i].v, tbl[i].dn, tbl[i].e, tbl[i].o});
    end
    start = 0; abort = 0; omode = 2'd0;
    repeat (30) cycle();

    // BIT_CYCLES=3, D=81, DIR=1: per-cycle profile of the scan.
    start = 1; d = 8'h81; dir = 1;
    cycle();
    start = 0; d = 8'h00; dir = 0;
    busy_n = 0; bv_n = 0; bv_first = 0; bv_last = 0; done_n = 0; done_c = 0;
    for (int c = 1; c <= 30; c++) begin
      if (bus3.BUSY) busy_n++;
      if (bus3.BIT_VALID) begin
        bv_n++;
        if (bv_first == 0) bv_first = c;
        bv_last = c;
      end
      if (bus3.DONE) begin
        done_n++;
        done_c = c;
      end
      if (c == 1)  check("bc3_sel_c1", s3, 3'd7);
      if (c == 4)  check("bc3_sel_c4", s3, 3'd6);
      if (c == 24) check("bc3_sel_c24", s3, 3'd0);
      cycle();
    end
    check("bc3_busy_cycles", busy_n, 24);
    check("bc3_strobes", bv_n, 8);
    check("bc3_first_strobe", bv_first, 1);
    check("bc3_last_strobe", bv_last, 22);
    check("bc3_done_pulses", done_n, 1);
    check("bc3_done_cycle", done_c, 25);
    check("bc3_err", bus3.ERR, 1'b0);

    // Asynchronous reset between edges in the middle of a scan.
    start = 1; d = 8'h5A; dir = 0;
    cycle();
    start = 0;
    repeat (3) cycle();
    RST_N = 1'b0;
    #1;
    m_reset();
    check("async_rst_bc1", act1, 15'd0);
    check("async_rst_bc3", act3, 15'd0);
    @(posedge CLK);
    #1;
    check("rst_held_bc1", act1, 15'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    cycle();
    start = 1; d = 8'h3C; dir = 0;
    cycle();
    check("post_rst_word", i1, 8'h3C);
    start = 0;
    repeat (28) cycle();

    // Randomized traffic against the model.
    repeat (600) begin
      start  = ($urandom_range(0, 3) == 0);
      abort  = ($urandom_range(0, 19) == 0);
      dir    = 1'($urandom_range(0, 1));
      d      = 8'($urandom);
      o_rand = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        4:       omode = 2'd1;
        5:       omode = 2'd2;
        default: omode = 2'd0;
      endcase
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
